// File: rtl/tcb_lite_memory_if.sv
// TCB-lite bus bundle: per-port request/response vectors, port i in slice i.
interface tcb_lite_memory_if #(
    parameter int IFN = 1,
    parameter int ADR = 32,
    parameter int DAT = 32
) ();
    localparam int BEN = DAT / 8;
    localparam int ALN = $clog2(BEN);
    localparam int SZW = ($clog2(ALN + 1) > 1) ? $clog2(ALN + 1) : 1;

    logic [IFN-1:0]     tcb_vld;
    logic [IFN-1:0]     tcb_rdy;
    logic [IFN-1:0]     tcb_wen;
    logic [IFN-1:0]     tcb_ndn;
    logic [IFN*ADR-1:0] tcb_adr;
    logic [IFN*SZW-1:0] tcb_siz;
    logic [IFN*BEN-1:0] tcb_ben;
    logic [IFN*DAT-1:0] tcb_wdt;
    logic [IFN-1:0]     tcb_rsp;
    logic [IFN*DAT-1:0] tcb_rdt;
    logic [IFN-1:0]     tcb_sts;

    modport master (
        output tcb_vld, tcb_wen, tcb_ndn, tcb_adr, tcb_siz, tcb_ben, tcb_wdt,
        input  tcb_rdy, tcb_rsp, tcb_rdt, tcb_sts
    );

    modport slave (
        input  tcb_vld, tcb_wen, tcb_ndn, tcb_adr, tcb_siz, tcb_ben, tcb_wdt,
        output tcb_rdy, tcb_rsp, tcb_rdt, tcb_sts
    );
endinterface

// File: rtl/tcb_lite_memory.sv
// Multi-port TCB-lite memory model with fixed-latency response pipeline.
// Optional big-endian lane swapping is enabled with TCB_LITE_MEMORY_BIGENDIAN_EN.
module tcb_lite_memory #(
    parameter int IFN = 1,
    parameter int SIZ = 256,
    parameter int ADR = 32,
    parameter int DAT = 32,
    parameter int DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    tcb_lite_memory_if.slave tcb
);
    localparam int BEN = DAT / 8;
    localparam int ALN = $clog2(BEN);
    localparam int SZW = ($clog2(ALN + 1) > 1) ? $clog2(ALN + 1) : 1;
    localparam int AW  = $clog2(SIZ);

    logic [7:0]                       mem_q [SIZ];
    logic [IFN-1:0]                   xfr_s;
    logic [IFN-1:0]                   err_s;
    logic [IFN-1:0][BEN-1:0]          we_s;
    logic [IFN-1:0][BEN-1:0][7:0]     wb_s;
    logic [IFN-1:0][BEN-1:0][AW-1:0]  idx_s;
    logic [IFN-1:0][DAT-1:0]          rdt_s;

    logic [DLY-1:0][IFN-1:0]          rsp_q, rsp_d;
    logic [DLY-1:0][IFN-1:0]          sts_q, sts_d;
    logic [DLY-1:0][IFN-1:0][DAT-1:0] rdt_q, rdt_d;

    logic unused_s;
    assign unused_s = ^{tcb.tcb_adr, tcb.tcb_ndn};

    // Per-port decode: alignment check, active window, lane mapping and read data.
    always_comb begin
        logic [AW-1:0]  eff_v;
        logic [AW-1:0]  base_v;
        logic [SZW-1:0] siz_v;
        int             off_v;
        int             num_v;
        int             src_v;
        xfr_s  = '0;
        err_s  = '0;
        we_s   = '0;
        wb_s   = '0;
        idx_s  = '0;
        rdt_s  = '0;
        eff_v  = '0;
        base_v = '0;
        siz_v  = '0;
        off_v  = 0;
        num_v  = 1;
        src_v  = 0;
        for (int p = 0; p < IFN; p++) begin
            eff_v    = tcb.tcb_adr[p*ADR +: AW];
            siz_v    = tcb.tcb_siz[p*SZW +: SZW];
            base_v   = eff_v & ~AW'(BEN - 1);
            off_v    = int'(eff_v & AW'(BEN - 1));
            num_v    = int'(32'd1 << siz_v);
            xfr_s[p] = tcb.tcb_vld[p] & ~rst;
            err_s[p] = (int'(siz_v) > ALN) || ((off_v % num_v) != 32'sd0);
            for (int k = 0; k < BEN; k++) begin
                idx_s[p][k] = base_v + AW'(k);
`ifdef TCB_LITE_MEMORY_BIGENDIAN_EN
                // Lane off+j pairs with lane off+num-1-j inside the window.
                if (tcb.tcb_ndn[p]) begin
                    src_v = 2 * off_v + num_v - 1 - k;
                end else begin
                    src_v = k;
                end
`else
                src_v = k;
`endif
                if (xfr_s[p] && !err_s[p] && (k >= off_v) && (k < off_v + num_v)) begin
                    we_s[p][k] = tcb.tcb_wen[p] & tcb.tcb_ben[p*BEN + k];
                    wb_s[p][k] = tcb.tcb_wdt[p*DAT + 8*src_v +: 8];
                    if (!tcb.tcb_wen[p]) begin
                        rdt_s[p][8*k +: 8] = mem_q[base_v + AW'(src_v)];
                    end else begin
                        rdt_s[p][8*k +: 8] = 8'h00;
                    end
                end else begin
                    we_s[p][k] = 1'b0;
                    wb_s[p][k] = 8'h00;
                end
            end
        end
    end

    // Byte array update; ascending port order lets the highest port win a shared byte.
    always_ff @(posedge clk) begin
        for (int p = 0; p < IFN; p++) begin
            for (int k = 0; k < BEN; k++) begin
                if (we_s[p][k]) begin
                    mem_q[idx_s[p][k]] <= wb_s[p][k];
                end
            end
        end
    end

    // Response pipeline next state: stage 0 captures this cycle's accepts.
    always_comb begin
        rsp_d    = rsp_q;
        sts_d    = sts_q;
        rdt_d    = rdt_q;
        rsp_d[0] = xfr_s;
        sts_d[0] = xfr_s & err_s;
        rdt_d[0] = rdt_s;
        for (int d = 1; d < DLY; d++) begin
            rsp_d[d] = rsp_q[d-1];
            sts_d[d] = sts_q[d-1];
            rdt_d[d] = rdt_q[d-1];
        end
    end

    // Response pipeline registers, flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= '0;
            sts_q <= '0;
            rdt_q <= '0;
        end else begin
            rsp_q <= rsp_d;
            sts_q <= sts_d;
            rdt_q <= rdt_d;
        end
    end

    // Bus outputs, held quiet during reset; no backpressure otherwise.
    always_comb begin
        if (rst) begin
            tcb.tcb_rdy = '0;
            tcb.tcb_rsp = '0;
            tcb.tcb_sts = '0;
            tcb.tcb_rdt = '0;
        end else begin
            tcb.tcb_rdy = '1;
            tcb.tcb_rsp = rsp_q[DLY-1];
            tcb.tcb_sts = sts_q[DLY-1];
            tcb.tcb_rdt = rdt_q[DLY-1];
        end
    end
endmodule

// File: tb/tb_tcb_lite_memory.sv
// Randomized bench for tcb_lite_memory (2 ports, DLY=2) against a byte-array reference model.
module tb_tcb_lite_memory;
    localparam int IFN = 2;
    localparam int SIZ = 256;
    localparam int DLY = 2;
    localparam int BEN = 4;

    typedef logic [IFN-1:0][34:0] exp_t;

    logic clk;
    logic rst;

    logic [IFN-1:0] v_r, w_r, n_r;
    logic [31:0]    a_r [IFN];
    logic [31:0]    d_r [IFN];
    logic [1:0]     s_r [IFN];
    logic [3:0]     b_r [IFN];

    logic [7:0] mem_m [SIZ];
    exp_t       exp_q [$];
    int         n_checks;
    int         n_errors;

    tcb_lite_memory_if #(.IFN(IFN), .ADR(32), .DAT(32)) bus ();

    tcb_lite_memory #(.IFN(IFN), .SIZ(SIZ), .ADR(32), .DAT(32), .DLY(DLY)) dut (
        .clk (clk),
        .rst (rst),
        .tcb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic w, input logic [31:0] a,
                            input logic [1:0] s, input logic [3:0] b, input logic [31:0] d);
        v_r[p] = v;
        w_r[p] = w;
        n_r[p] = 1'b0;
        a_r[p] = a;
        s_r[p] = s;
        b_r[p] = b;
        d_r[p] = d;
    endtask

    task automatic idle_all();
        for (int p = 0; p < IFN; p++) set_port(p, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);
    endtask

    // One clock: drive, predict, advance, compare the response now due.
    task automatic step();
        exp_t        e;
        int          eff, off, num;
        logic        mis;
        logic [31:0] rd;
        e = '0;
        bus.tcb_vld = v_r;
        bus.tcb_wen = w_r;
        bus.tcb_ndn = n_r;
        bus.tcb_adr = {a_r[1], a_r[0]};
        bus.tcb_siz = {s_r[1], s_r[0]};
        bus.tcb_ben = {b_r[1], b_r[0]};
        bus.tcb_wdt = {d_r[1], d_r[0]};
        if (!rst) begin
            for (int p = 0; p < IFN; p++) begin
                if (v_r[p]) begin
                    eff = int'(a_r[p] % SIZ);
                    num = 1 << s_r[p];
                    off = eff % BEN;
                    mis = (s_r[p] > 2'd2) || ((eff % num) != 0);
                    rd  = 32'h0;
                    if (!w_r[p] && !mis) begin
                        for (int j = 0; j < num; j++) rd = rd | (32'(mem_m[eff+j]) << (8*(off+j)));
                    end
                    e[p] = {1'b1, mis, ~w_r[p], rd};
                end
            end
            for (int p = 0; p < IFN; p++) begin
                if (v_r[p] && w_r[p] && !e[p][33]) begin
                    eff = int'(a_r[p] % SIZ);
                    num = 1 << s_r[p];
                    off = eff % BEN;
                    for (int j = 0; j < num; j++) begin
                        if (b_r[p][off+j]) mem_m[eff+j] = 8'(d_r[p] >> (8*(off+j)));
                    end
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (rst) e = '0;
        check("rdy", 64'(bus.tcb_rdy), rst ? 64'd0 : 64'd3);
        for (int p = 0; p < IFN; p++) begin
            check($sformatf("rsp%0d", p), 64'(bus.tcb_rsp[p]), 64'(e[p][34]));
            if (e[p][34]) begin
                check($sformatf("sts%0d", p), 64'(bus.tcb_sts[p]), 64'(e[p][33]));
                if (e[p][32]) check($sformatf("rdt%0d", p), 64'(bus.tcb_rdt[p*32 +: 32]), 64'(e[p][31:0]));
            end else begin
                check($sformatf("idle_sts%0d", p), 64'(bus.tcb_sts[p]), 64'd0);
                check($sformatf("idle_rdt%0d", p), 64'(bus.tcb_rdt[p*32 +: 32]), 64'd0);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_all();
        for (int i = 0; i < DLY - 1; i++) exp_q.push_back('0);
        repeat (3) step();
        rst = 1'b0;

        // Fill the whole array so every later read is defined.
        for (int i = 0; i < SIZ / 8; i++) begin
            set_port(0, 1'b1, 1'b1, 32'(8*i),     2'd2, 4'hF, $urandom);
            set_port(1, 1'b1, 1'b1, 32'(8*i + 4), 2'd2, 4'hF, $urandom);
            step();
        end
        idle_all();

        set_port(0, 1'b1, 1'b1, 32'h00, 2'd2, 4'hF, 32'h01234567); step();
        set_port(0, 1'b1, 1'b0, 32'h00, 2'd2, 4'hF, 32'h0);        step();
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, 1'b0, 32'(i), 2'd0, 4'h0, 32'h0); step();
        end
        set_port(0, 1'b1, 1'b1, 32'h11, 2'd2, 4'hF, 32'hDEADBEEF); step();
        set_port(0, 1'b1, 1'b0, 32'h11, 2'd2, 4'hF, 32'h0);        step();
        set_port(0, 1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);        step();
        set_port(0, 1'b1, 1'b1, 32'h12, 2'd3, 4'hF, 32'h0);        step();
        set_port(0, 1'b1, 1'b1, 32'h05, 2'd0, 4'b0010, 32'h0000AB00); step();
        set_port(0, 1'b1, 1'b0, 32'h04, 2'd2, 4'h0, 32'h0);        step();
        set_port(0, 1'b1, 1'b1, 32'h105, 2'd0, 4'b0010, 32'h00005C00); step();
        set_port(0, 1'b1, 1'b0, 32'h104, 2'd2, 4'h0, 32'h0);       step();
        set_port(0, 1'b1, 1'b1, 32'h0A, 2'd1, 4'b1100, 32'hBEEF0000); step();
        set_port(0, 1'b1, 1'b0, 32'h08, 2'd2, 4'h0, 32'h0);        step();
        idle_all();
        step();

        // Back-to-back and gapped alternating write/read traffic.
        for (int i = 0; i < 18; i++) begin
            set_port(0, 1'b1, (i % 2 == 0), 32'h20 + 32'(4*(i/2)), 2'd2, 4'hF, $urandom);
            step();
            idle_all();
            repeat (i % 3) step();
        end

        // Two ports hitting the same word.
        set_port(0, 1'b1, 1'b1, 32'h00, 2'd2, 4'hF, 32'h11111111);
        set_port(1, 1'b1, 1'b1, 32'h00, 2'd2, 4'hF, 32'h22222222); step();
        set_port(0, 1'b1, 1'b0, 32'h00, 2'd2, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b1, 32'h00, 2'd2, 4'hF, 32'h33333333); step();
        set_port(0, 1'b1, 1'b0, 32'h00, 2'd2, 4'hF, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);          step();
        idle_all();

        // Random traffic on both ports.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < IFN; p++) begin
                set_port(p, 1'($urandom), 1'($urandom), $urandom, 2'($urandom_range(3, 0)),
                         4'($urandom), $urandom);
                n_r[p] = 1'($urandom);
            end
            step();
        end
        idle_all();

        // Reset with a read in flight: response suppressed, contents kept.
        set_port(0, 1'b1, 1'b0, 32'h00, 2'd2, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h44, 2'd2, 4'hF, 32'h0); step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        idle_all();
        step();
        for (int i = 0; i < SIZ / 8; i++) begin
            set_port(0, 1'b1, 1'b0, 32'(8*i),     2'd2, 4'h0, 32'h0);
            set_port(1, 1'b1, 1'b0, 32'(8*i + 4), 2'd2, 4'h0, 32'h0);
            step();
        end
        idle_all();
        repeat (DLY + 1) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
